// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scrub controller: codeword geometry,
// bit positions of the Hamming(7,4)+parity code, FSM state encoding and
// the SECDED encoder used for write-back.
// Optional feature macro: SCRUB_WRITEBACK_EN (adds the SCRUB_WB state).
package ecc_pkg;

  localparam int CODE_W = 8;
  localparam int DATA_W = 4;

  // Codeword bit indices (Hamming positions 1..7 live in bits 0..6).
  localparam int P1_BIT  = 0;
  localparam int P2_BIT  = 1;
  localparam int D0_BIT  = 2;
  localparam int P4_BIT  = 3;
  localparam int D1_BIT  = 4;
  localparam int D2_BIT  = 5;
  localparam int D3_BIT  = 6;
  localparam int PAR_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_RD,
    ST_HOST_CHK,
    ST_SCRUB_RD,
`ifdef SCRUB_WRITEBACK_EN
    ST_SCRUB_CHK,
    ST_SCRUB_WB
`else
    ST_SCRUB_CHK
`endif
  } state_e;

  // Build a clean codeword from four data bits.
  function automatic logic [CODE_W-1:0] secded_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c          = '0;
    c[D0_BIT]  = d[0];
    c[D1_BIT]  = d[1];
    c[D2_BIT]  = d[2];
    c[D3_BIT]  = d[3];
    c[P1_BIT]  = d[0] ^ d[1] ^ d[3];
    c[P2_BIT]  = d[0] ^ d[2] ^ d[3];
    c[P4_BIT]  = d[1] ^ d[2] ^ d[3];
    c[PAR_BIT] = ^c[PAR_BIT-1:0];
    return c;
  endfunction

endpackage

// File: rtl/secded_dec.sv
// Combinational SECDED decoder: corrects single-bit errors, flags
// double-bit errors, and re-encodes the corrected data so a scrub can
// write back a clean codeword.
module secded_dec
  import ecc_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic              err_1bit,
  output logic              err_2bit,
  output logic [CODE_W-1:0] recoded
);

  logic [2:0]        syn;
  logic              par_fail;
  logic [CODE_W-1:0] fixed;

  // Syndrome, overall parity and single-bit correction.
  // NOTE: every output of an always_comb gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    syn[0]   = code[P1_BIT] ^ code[D0_BIT] ^ code[D1_BIT] ^ code[D3_BIT];
    syn[1]   = code[P2_BIT] ^ code[D0_BIT] ^ code[D2_BIT] ^ code[D3_BIT];
    syn[2]   = code[P4_BIT] ^ code[D1_BIT] ^ code[D2_BIT] ^ code[D3_BIT];
    par_fail = ^code;
    fixed    = code;
    // Only flip a bit when parity agrees it is a single error; a non-zero
    // syndrome with good parity is a double error and is left untouched.
    for (int i = 0; i < 7; i++) begin
      if (par_fail && (syn == 3'(i + 1))) begin
        fixed[i] = ~code[i];
      end
    end
    // Parity failure alone (syndrome zero) is the parity bit itself: data good.
    err_1bit = par_fail;
    err_2bit = (syn != 3'd0) && !par_fail;
    data     = {fixed[D3_BIT], fixed[D2_BIT], fixed[D1_BIT], fixed[D0_BIT]};
    recoded  = secded_encode(data);
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ECC scrub controller: serves host reads through a SECDED decoder and,
// after a programmable idle interval, walks the RAM re-checking entries.
// Optional feature macro: SCRUB_WRITEBACK_EN -- when defined, corrected
// single-bit errors found by the scrubber are written back to the RAM.
module ecc_scrub_ctrl
  import ecc_pkg::*;
#(
  parameter  int DEPTH          = 16,
  parameter  int SCRUB_INTERVAL = 256,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_data,
  output logic              o_1bit_error,
  output logic              o_2bit_error,
  output logic [AW-1:0]     o_mem_addr,
  output logic              o_mem_rd,
  input  logic [CODE_W-1:0] i_mem_code,
  output logic              o_mem_wr,
  output logic [CODE_W-1:0] o_mem_code,
  output logic [7:0]        o_corr_count,
  output logic [7:0]        o_uncorr_count,
  output logic              o_busy
);

  localparam int TW = $clog2(SCRUB_INTERVAL + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     scrub_ptr_q;
  logic [TW-1:0]     timer_q;
  logic              pending_q;
  logic [7:0]        corr_q;
  logic [7:0]        uncorr_q;
  logic              scrub_done;

  logic [DATA_W-1:0] dec_data;
  logic              dec_1bit;
  logic              dec_2bit;
  logic [CODE_W-1:0] dec_recoded;

  // One decoder shared by host and scrub paths; the RAM returns data one
  // cycle after the read strobe, i.e. in the *_CHK states.
  secded_dec u_dec (
    .code     (i_mem_code),
    .data     (dec_data),
    .err_1bit (dec_1bit),
    .err_2bit (dec_2bit),
    .recoded  (dec_recoded)
  );

`ifdef SCRUB_WRITEBACK_EN
  logic [CODE_W-1:0] wb_code_q;

  // Capture the clean codeword during SCRUB_CHK for the write-back cycle.
  // NOTE: pure datapath register, only read in SCRUB_WB after being loaded,
  // so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_SCRUB_CHK) begin
      wb_code_q <= dec_recoded;
    end
  end
`else
  logic unused_recoded;
  assign unused_recoded = ^dec_recoded;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and all memory/host strobes.
  always_comb begin
    state_d      = state_q;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_addr   = '0;
    o_mem_code   = '0;
    o_ack        = 1'b0;
    o_data       = '0;
    o_1bit_error = 1'b0;
    o_2bit_error = 1'b0;
    scrub_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Host has priority over a pending scrub.
        if (i_req) begin
          state_d = ST_HOST_RD;
        end else if (pending_q) begin
          state_d = ST_SCRUB_RD;
        end
      end
      ST_HOST_RD: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = i_addr;
        state_d    = ST_HOST_CHK;
      end
      ST_HOST_CHK: begin
        o_ack        = 1'b1;
        o_data       = dec_data;
        o_1bit_error = dec_1bit;
        o_2bit_error = dec_2bit;
        state_d      = ST_IDLE;
      end
      ST_SCRUB_RD: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = scrub_ptr_q;
        state_d    = ST_SCRUB_CHK;
      end
      ST_SCRUB_CHK: begin
`ifdef SCRUB_WRITEBACK_EN
        if (dec_1bit) begin
          state_d = ST_SCRUB_WB;
        end else begin
          state_d    = ST_IDLE;
          scrub_done = 1'b1;
        end
`else
        state_d    = ST_IDLE;
        scrub_done = 1'b1;
`endif
      end
`ifdef SCRUB_WRITEBACK_EN
      ST_SCRUB_WB: begin
        o_mem_wr   = 1'b1;
        o_mem_addr = scrub_ptr_q;
        o_mem_code = wb_code_q;
        state_d    = ST_IDLE;
        scrub_done = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Interval timer, scrub request flag and scrub address pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer_q     <= '0;
      pending_q   <= 1'b0;
      scrub_ptr_q <= '0;
    end else if (scrub_done) begin
      // DEPTH is a power of two, so the pointer wraps naturally.
      pending_q   <= 1'b0;
      scrub_ptr_q <= scrub_ptr_q + 1'b1;
    end else if ((state_q == ST_IDLE) && !pending_q) begin
      if (timer_q == TW'(SCRUB_INTERVAL - 1)) begin
        pending_q <= 1'b1;
        timer_q   <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // Saturating scrub error counters; host reads never touch them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (state_q == ST_SCRUB_CHK) begin
      if (dec_1bit && (corr_q != 8'hFF)) begin
        corr_q <= corr_q + 8'd1;
      end
      if (dec_2bit && (uncorr_q != 8'hFF)) begin
        uncorr_q <= uncorr_q + 8'd1;
      end
    end
  end

  assign o_corr_count   = corr_q;
  assign o_uncorr_count = uncorr_q;
  assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a one-cycle-latency RAM model.
// Honours SCRUB_WRITEBACK_EN to pick the expected scrub behaviour.
module tb_ecc_scrub_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_req;
  logic [3:0] i_addr;
  logic       o_ack;
  logic [3:0] o_data;
  logic       o_1bit_error;
  logic       o_2bit_error;
  logic [3:0] o_mem_addr;
  logic       o_mem_rd;
  logic [7:0] i_mem_code;
  logic       o_mem_wr;
  logic [7:0] o_mem_code;
  logic [7:0] o_corr_count;
  logic [7:0] o_uncorr_count;
  logic       o_busy;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  // RAM model: init_mem is owned by the stimulus, wb_mem/wb_valid by writes.
  logic [7:0]  init_mem [DEPTH];
  logic [7:0]  wb_mem   [DEPTH];
  logic [15:0] wb_valid = '0;
  logic        mem_clr  = 1'b0;
  int          wr_seen  = 0;

  always #5 clk = ~clk;

  ecc_scrub_ctrl #(.DEPTH(DEPTH), .SCRUB_INTERVAL(4)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .o_ack          (o_ack),
    .o_data         (o_data),
    .o_1bit_error   (o_1bit_error),
    .o_2bit_error   (o_2bit_error),
    .o_mem_addr     (o_mem_addr),
    .o_mem_rd       (o_mem_rd),
    .i_mem_code     (i_mem_code),
    .o_mem_wr       (o_mem_wr),
    .o_mem_code     (o_mem_code),
    .o_corr_count   (o_corr_count),
    .o_uncorr_count (o_uncorr_count),
    .o_busy         (o_busy)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      wb_valid <= '0;
    end else if (o_mem_wr) begin
      wb_mem[o_mem_addr]   <= o_mem_code;
      wb_valid[o_mem_addr] <= 1'b1;
      wr_seen              <= wr_seen + 1;
    end
    if (o_mem_rd) begin
      i_mem_code <= wb_valid[o_mem_addr] ? wb_mem[o_mem_addr] : init_mem[o_mem_addr];
    end
  end

  function automatic logic [7:0] mem_view(input int a);
    return wb_valid[a] ? wb_mem[a] : init_mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_clr = 1'b1;
    i_rst   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    tick();
    tick();
    i_rst   = 1'b0;
    mem_clr = 1'b0;
    mon_en  = 1'b1;
  endtask

  // Host read right after reset: ack exactly two cycles after request.
  task automatic host_read(input string tag, input logic [3:0] addr, input logic [7:0] code,
                           input logic [3:0] exp_data, input logic exp_1, input logic exp_2);
    int wr0;
    do_reset();
    init_mem[addr] = code;
    wr0    = wr_seen;
    i_req  = 1'b1;
    i_addr = addr;
    tick();
    check({tag, "_rd"}, {o_mem_rd, o_ack}, 2'b10);
    check({tag, "_rd_addr"}, o_mem_addr, addr);
    tick();
    check({tag, "_ack"}, o_ack, 1'b1);
    check({tag, "_data"}, o_data, exp_data);
    check({tag, "_flags"}, {o_1bit_error, o_2bit_error}, {exp_1, exp_2});
    check({tag, "_nowr"}, o_mem_wr, 1'b0);
    i_req = 1'b0;
    tick();
    check({tag, "_ack_drop"}, o_ack, 1'b0);
    check({tag, "_counts"}, {o_corr_count, o_uncorr_count}, 16'h0000);
    check({tag, "_no_writes"}, wr_seen - wr0, 0);
    init_mem[addr] = 8'hD2;
  endtask

  // Step until the scrubber issues its next read, bounded.
  task automatic wait_scrub_rd(input string tag, input logic [3:0] exp_addr);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_mem_rd && (n < 20));
    check({tag, "_seen"}, o_mem_rd, 1'b1);
    check(tag, o_mem_addr, exp_addr);
  endtask

  // Strobe sanity on every cycle: never read+write, nothing while idle.
  always @(negedge clk) begin
    if (mon_en && !i_rst) begin
      check("mem_strobes", {o_mem_rd & o_mem_wr, ~o_busy & (o_mem_rd | o_mem_wr)}, 2'b00);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int wr0;
    i_rst  = 1'b1;
    i_req  = 1'b0;
    i_addr = '0;
    for (int i = 0; i < DEPTH; i++) init_mem[i] = 8'hD2;

    // Reset state.
    do_reset();
    check("rst_busy_ack", {o_busy, o_ack}, 2'b00);
    check("rst_data_flags", {o_data, o_1bit_error, o_2bit_error}, 6'h00);
    check("rst_strobes", {o_mem_rd, o_mem_wr}, 2'b00);
    check("rst_counts", {o_corr_count, o_uncorr_count}, 16'h0000);

    // Host reads: clean, data-bit error, parity-bit error, double error.
    host_read("h_clean", 4'd3, 8'hD2, 4'hA, 1'b0, 1'b0);
    host_read("h_d0", 4'd3, 8'hD6, 4'hA, 1'b1, 1'b0);
    host_read("h_par", 4'd3, 8'h52, 4'hA, 1'b1, 1'b0);
    host_read("h_2bit", 4'd3, 8'hD1, 4'hA, 1'b0, 1'b1);
    host_read("h_zero", 4'd9, 8'h00, 4'h0, 1'b0, 1'b0);

    // Host and scrub both pending in IDLE: host first, scrub after.
    do_reset();
    repeat (4) tick();
    check("arb_idle", o_busy, 1'b0);
    init_mem[5] = 8'hD6;
    i_req  = 1'b1;
    i_addr = 4'd5;
    tick();
    check("arb_host_rd", {o_mem_rd, o_mem_addr}, {1'b1, 4'd5});
    tick();
    check("arb_ack", {o_ack, o_data, o_1bit_error}, {1'b1, 4'hA, 1'b1});
    i_req = 1'b0;
    init_mem[5] = 8'hD2;
    tick();
    check("arb_idle_after_ack", {o_busy, o_ack}, 2'b00);
    tick();
    check("arb_scrub_rd", {o_mem_rd, o_mem_addr}, {1'b1, 4'd0});
    for (int k = 1; k <= 16; k++) begin
      wait_scrub_rd($sformatf("scrub_ptr_%0d", k), 4'(k % 16));
    end
    check("walk_counts", {o_corr_count, o_uncorr_count}, 16'h0000);

    // Correctable error found by the scrubber.
    do_reset();
    init_mem[0] = 8'hD6;
    wr0 = wr_seen;
    wait_scrub_rd("sc_first", 4'd0);
    tick();
    check("sc_chk", {o_busy, o_mem_wr, o_corr_count}, {1'b1, 1'b0, 8'd0});
    tick();
`ifdef SCRUB_WRITEBACK_EN
    check("sc_wb", {o_mem_wr, o_mem_addr, o_mem_code}, {1'b1, 4'd0, 8'hD2});
    check("sc_wb_count", o_corr_count, 8'd1);
    tick();
    check("sc_done", o_busy, 1'b0);
    check("sc_mem0", mem_view(0), 8'hD2);
    check("sc_writes", wr_seen - wr0, 1);
`else
    check("sc_done", {o_busy, o_mem_wr}, 2'b00);
    check("sc_count", o_corr_count, 8'd1);
    tick();
    check("sc_mem0", mem_view(0), 8'hD6);
    check("sc_writes", wr_seen - wr0, 0);
`endif
    check("sc_uncorr", o_uncorr_count, 8'd0);
    wait_scrub_rd("sc_next", 4'd1);
    init_mem[0] = 8'hD2;

    // Uncorrectable scrubs: counter saturates, nothing written back.
    do_reset();
    for (int i = 0; i < DEPTH; i++) init_mem[i] = 8'hD1;
    wr0 = wr_seen;
    repeat (2200) tick();
    check("sat_uncorr", o_uncorr_count, 8'd255);
    check("sat_corr", o_corr_count, 8'd0);
    check("sat_writes", wr_seen - wr0, 0);

    // Reset during HOST_RD drops the request.
    for (int k = 0; k < 10 && o_busy; k++) tick();
    check("rr_idle", o_busy, 1'b0);
    i_req  = 1'b1;
    i_addr = 4'd3;
    tick();
    check("rr_host_rd", {o_mem_rd, o_mem_addr}, {1'b1, 4'd3});
    i_rst = 1'b1;
    i_req = 1'b0;
    tick();
    check("rr_state", {o_busy, o_ack, o_mem_rd, o_mem_wr}, 4'b0000);
    check("rr_data", {o_data, o_1bit_error, o_2bit_error}, 6'h00);
    check("rr_counts", {o_corr_count, o_uncorr_count}, 16'h0000);
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_no_ack_%0d", k), {o_ack, o_busy}, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: number of codeword entries in the external RAM (power of two).
REQ-002 Parameter SCRUB_INTERVAL, default 256: idle cycles between scrub operations.
REQ-003 i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  1  host read request; held until o_ack.
REQ-006 i_addr  input  log2(DEPTH)  host read address; stable while i_req high.
REQ-007 o_ack  output  1  one-cycle pulse; o_data and flags valid in the same cycle.
REQ-008 o_data  output  4  corrected host read data.
REQ-009 o_1bit_error / o_2bit_error  output  1 each  host-read flags, valid with o_ack.
REQ-010 o_mem_addr  output  log2(DEPTH); o_mem_rd  output  1; i_mem_code  input  8  read data, one-cycle read latency.
REQ-011 o_mem_wr  output  1; o_mem_code  output  8  write-back codeword.
REQ-012 o_corr_count / o_uncorr_count  output  8 each  saturating scrub error counters.
REQ-013 o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 Codeword bit layout: bits[6:0] = Hamming(7,4) positions 1..7 (p1,p2,d0,p4,d1,d2,d3); bit[7] = overall even parity.
REQ-015 Decode: syndrome != 0 with parity fail = 1-bit error, corrected; syndrome == 0 with parity fail = parity-bit error, data good, counted as 1-bit; syndrome != 0 with parity good = 2-bit error, data uncorrected.
REQ-016 FSM states: IDLE, HOST_RD, HOST_CHK, SCRUB_RD, SCRUB_CHK, SCRUB_WB.
REQ-017 IDLE -> HOST_RD when i_req=1; else IDLE -> SCRUB_RD when scrub_pending=1; host wins when both are pending.
REQ-018 HOST_RD: o_mem_rd=1, o_mem_addr=i_addr, for one cycle; then -> HOST_CHK.
REQ-019 HOST_CHK: o_ack=1 with decoded o_data and flags; -> IDLE. o_ack rises two cycles after i_req is sampled in IDLE.
REQ-020 Host reads never write back and never update the counters.
REQ-021 Interval timer counts cycles only in IDLE while scrub_pending=0; at SCRUB_INTERVAL-1 it sets scrub_pending and clears itself.
REQ-022 SCRUB_RD: o_mem_rd=1, o_mem_addr=scrub_ptr; -> SCRUB_CHK.
REQ-023 SCRUB_CHK: no error -> IDLE; 1-bit error -> o_corr_count+1, then -> SCRUB_WB; 2-bit error -> o_uncorr_count+1, then -> IDLE, no write.
REQ-024 SCRUB_WB: o_mem_wr=1, o_mem_code = re-encoded corrected codeword at scrub_ptr; -> IDLE.
REQ-025 On leaving SCRUB_CHK/SCRUB_WB to IDLE: scrub_ptr increments, wrapping DEPTH-1 -> 0, and scrub_pending clears.
REQ-026 A scrub sequence is not preempted; i_req arriving mid-scrub is served on the first IDLE cycle after the scrub.
REQ-027 Counters saturate at 255 and do not wrap.
REQ-028 o_mem_rd and o_mem_wr are never both high; both are low in IDLE.

Reset
REQ-029 i_rst=1 at any edge: state=IDLE, scrub_ptr=0, timer=0, scrub_pending=0, counters=0, o_ack=0, o_mem_rd=0, o_mem_wr=0, o_data=0, flags=0; an in-flight host request is dropped.

Configuration
REQ-030 Macro SCRUB_WRITEBACK_EN defined: behaviour as REQ-023/024.
REQ-031 SCRUB_WRITEBACK_EN undefined: SCRUB_WB is absent, o_mem_wr is tied 0, a 1-bit error only counts, then -> IDLE.

Structure
REQ-032 Package ecc_pkg holds the FSM state enum, CODE_W=8, DATA_W=4 and the parity-position constants.
REQ-033 Sub-module secded_dec: combinational 8-bit codeword in -> 4-bit data, 1bit/2bit flags and re-encoded 8-bit codeword out; instantiated once and shared by host and scrub paths.

Verification
REQ-034 Memory holds 0xD2 (data 0xA); host reads addr 3 -> o_ack two cycles later, o_data=0xA, both flags 0.
REQ-035 Memory holds 0xD6 (d0 flipped); host read -> o_data=0xA, o_1bit_error=1, no write; memory holds 0x52 -> o_data=0xA, o_1bit_error=1.
REQ-036 Memory holds 0xD1 (p1 and p2 flipped); host read -> o_2bit_error=1, o_1bit_error=0.
REQ-037 SCRUB_INTERVAL=4; entry 0 holds 0xD6 -> scrub reads addr 0, writes 0xD2 to addr 0, o_corr_count=1, scrub_ptr=1; without macro -> no write, count=1.
REQ-038 i_req asserted in the same cycle scrub_pending sets -> host served first; scrub begins the cycle after o_ack; 16 scrubs wrap scrub_ptr to 0.
REQ-039 i_rst pulsed during HOST_RD -> no o_ack, all outputs at reset values the next cycle; 300 uncorrectable scrubs -> o_uncorr_count=255.
